// File: rtl/fourway_pkg.sv
// Shared definitions for the four-way direction front end: direction bit
// masks, axis indices, debounce states and the per-axis SOCD helpers.
package fourway_pkg;

  localparam logic [3:0] DIR_UP    = 4'b1000;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b0010;
  localparam logic [3:0] DIR_RIGHT = 4'b0001;

  // Axis index: pair {first, second} lives at bits [2*axis +: 2]
  localparam int DIR_HORIZONTAL = 0;
  localparam int DIR_VERTICAL   = 1;

  localparam logic [1:0] MODE_RAW  = 2'd0;
  localparam logic [1:0] MODE_SOCD = 2'd1;

  localparam logic [1:0] LAST_NONE   = 2'd0;
  localparam logic [1:0] LAST_FIRST  = 2'd1;
  localparam logic [1:0] LAST_SECOND = 2'd2;

  typedef enum logic [1:0] {S_LO, P_HI, S_HI, P_LO} db_state_t;

  // Resolve one axis: only a both-held pair is rewritten, by last press.
  function automatic logic [1:0] socd_resolve(input logic [1:0] pair,
                                              input logic [1:0] last);
    logic [1:0] res;
    res = pair;
    if (pair == 2'b11) begin
      case (last)
        LAST_FIRST:  res = 2'b10;
        LAST_SECOND: res = 2'b01;
        default:     res = 2'b00;
      endcase
    end
    return res;
  endfunction

  function automatic logic [1:0] last_update(input logic [1:0] rise,
                                             input logic [1:0] last);
    logic [1:0] res;
    case (rise)
      2'b11:   res = LAST_NONE;
      2'b10:   res = LAST_FIRST;
      2'b01:   res = LAST_SECOND;
      default: res = last;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dir_debounce_bit.sv
// One direction bit: four-state debounce FSM with a 4-bit persistence counter.
// stable_nxt exposes the value the stable bit takes on the next strobe.
module dir_debounce_bit
  import fourway_pkg::*;
#(
  parameter int DEBOUNCE = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sample_en,
  input  logic raw,
  output logic stable,
  output logic stable_nxt
);

  localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE - 1);

  db_state_t  state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    unique case (state)
      S_LO: if (raw) begin
        if (DEBOUNCE == 1) state_nxt = S_HI;
        else begin state_nxt = P_HI; cnt_nxt = 4'd1; end
      end
      S_HI: if (!raw) begin
        if (DEBOUNCE == 1) state_nxt = S_LO;
        else begin state_nxt = P_LO; cnt_nxt = 4'd1; end
      end
      P_HI: begin
        if (!raw)                 state_nxt = S_LO;
        else if (cnt == CNT_LAST) state_nxt = S_HI;
        else                      cnt_nxt   = cnt + 4'd1;
      end
      P_LO: begin
        if (raw)                  state_nxt = S_HI;
        else if (cnt == CNT_LAST) state_nxt = S_LO;
        else                      cnt_nxt   = cnt + 4'd1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_LO;
      cnt   <= '0;
    end else if (sample_en) begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign stable     = (state == S_HI) || (state == P_LO);
  assign stable_nxt = (state_nxt == S_HI) || (state_nxt == P_LO);

endmodule

// File: rtl/direction_history.sv
// Debounced direction front end with processed-vector feedback, change pulse
// and saturating hold counter. DIRECTION_HISTORY_SOCD_EN adds last-pressed-wins.
module direction_history
  import fourway_pkg::*;
#(
  parameter int DEBOUNCE = 3,
  parameter int HOLD_W   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sample_en,
  input  logic [3:0]        dirinput,
  input  logic [3:0]        processed,
  output logic [3:0]        dir_out,
  output logic [3:0]        oldp,
  output logic              dir_changed,
  output logic [HOLD_W-1:0] hold_count
);

  localparam int              NUM_LANES = 4;
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  logic [NUM_LANES-1:0] stable, stable_nxt;
  logic                 changed;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_bit
    dir_debounce_bit #(.DEBOUNCE(DEBOUNCE)) u_bit (
      .clk        (clk),
      .reset_n    (reset_n),
      .sample_en  (sample_en),
      .raw        (dirinput[i]),
      .stable     (stable[i]),
      .stable_nxt (stable_nxt[i])
    );
  end

  assign changed = (stable_nxt != stable);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      oldp        <= '0;
      dir_changed <= 1'b0;
      hold_count  <= '0;
    end else begin
      dir_changed <= sample_en && changed;
      if (sample_en) begin
        oldp <= processed;
        if (changed)               hold_count <= '0;
        else if (hold_count != '1) hold_count <= hold_count + HOLD_ONE;
      end
    end
  end

`ifdef DIRECTION_HISTORY_SOCD_EN
  logic [1:0]           last_v, last_h;
  logic [NUM_LANES-1:0] rise;

  assign rise = stable_nxt & ~stable;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_v <= LAST_NONE;
      last_h <= LAST_NONE;
    end else if (sample_en) begin
      last_v <= last_update(rise[2*DIR_VERTICAL +: 2], last_v);
      last_h <= last_update(rise[2*DIR_HORIZONTAL +: 2], last_h);
    end
  end

  assign dir_out = {socd_resolve(stable[2*DIR_VERTICAL +: 2], last_v),
                    socd_resolve(stable[2*DIR_HORIZONTAL +: 2], last_h)};
`else
  assign dir_out = stable;
`endif

endmodule

// File: tb/tb_direction_history.sv
// Bench for direction_history: a DEBOUNCE=3/HOLD_W=8 instance and a
// DEBOUNCE=1/HOLD_W=2 instance share stimulus and a run-length reference model.
module tb_direction_history;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       sample_en;
  logic [3:0] dirinput, processed;

  logic [3:0] a_dir, a_oldp, b_dir, b_oldp;
  logic       a_chg, b_chg;
  logic [7:0] a_hold;
  logic [1:0] b_hold;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  direction_history #(.DEBOUNCE(3), .HOLD_W(8)) u_a (
    .clk(clk), .reset_n(reset_n), .sample_en(sample_en), .dirinput(dirinput),
    .processed(processed), .dir_out(a_dir), .oldp(a_oldp),
    .dir_changed(a_chg), .hold_count(a_hold)
  );

  direction_history #(.DEBOUNCE(1), .HOLD_W(2)) u_b (
    .clk(clk), .reset_n(reset_n), .sample_en(sample_en), .dirinput(dirinput),
    .processed(processed), .dir_out(b_dir), .oldp(b_oldp),
    .dir_changed(b_chg), .hold_count(b_hold)
  );

  // Reference model: a bit flips once raw has differed from it on DEBOUNCE
  // consecutive strobes; run length counts those strobes.
  int         db_len[2]   = '{3, 1};
  int         hold_max[2] = '{255, 3};
  logic [3:0] m_st[2];
  int         m_run[2][4];
  int         m_hold[2];
  logic       m_chg[2];
  logic [3:0] m_oldp;
`ifdef DIRECTION_HISTORY_SOCD_EN
  int         m_lv[2], m_lh[2];
`endif

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = '0; m_hold[k] = 0; m_chg[k] = 1'b0;
      for (int b = 0; b < 4; b++) m_run[k][b] = 0;
`ifdef DIRECTION_HISTORY_SOCD_EN
      m_lv[k] = 0; m_lh[k] = 0;
`endif
    end
    m_oldp = '0;
  endtask

  task automatic model_strobe(input logic [3:0] din, input logic [3:0] proc);
    logic [3:0] prev, rise;
    for (int k = 0; k < 2; k++) begin
      prev = m_st[k];
      for (int b = 0; b < 4; b++) begin
        if (din[b] != m_st[k][b]) begin
          m_run[k][b]++;
          if (m_run[k][b] == db_len[k]) begin
            m_st[k][b]  = din[b];
            m_run[k][b] = 0;
          end
        end else m_run[k][b] = 0;
      end
      rise     = m_st[k] & ~prev;
      m_chg[k] = (m_st[k] != prev);
      if (m_chg[k]) m_hold[k] = 0;
      else if (m_hold[k] < hold_max[k]) m_hold[k]++;
`ifdef DIRECTION_HISTORY_SOCD_EN
      if (rise[3] && rise[2]) m_lv[k] = 0;
      else if (rise[3])       m_lv[k] = 1;
      else if (rise[2])       m_lv[k] = 2;
      if (rise[1] && rise[0]) m_lh[k] = 0;
      else if (rise[1])       m_lh[k] = 1;
      else if (rise[0])       m_lh[k] = 2;
`else
      if (rise == 4'hF) m_chg[k] = 1'b1;
`endif
    end
    m_oldp = proc;
  endtask

  function automatic logic [3:0] exp_dir(input int k);
    logic [3:0] d;
    d = m_st[k];
`ifdef DIRECTION_HISTORY_SOCD_EN
    if (d[3] && d[2]) begin
      d[3] = (m_lv[k] == 1);
      d[2] = (m_lv[k] == 2);
    end
    if (d[1] && d[0]) begin
      d[1] = (m_lh[k] == 1);
      d[0] = (m_lh[k] == 2);
    end
`endif
    return d;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("a.dir_out",     32'(a_dir),  32'(exp_dir(0)));
    check("a.oldp",        32'(a_oldp), 32'(m_oldp));
    check("a.dir_changed", 32'(a_chg),  32'(m_chg[0]));
    check("a.hold_count",  32'(a_hold), 32'(m_hold[0]));
    check("b.dir_out",     32'(b_dir),  32'(exp_dir(1)));
    check("b.oldp",        32'(b_oldp), 32'(m_oldp));
    check("b.dir_changed", 32'(b_chg),  32'(m_chg[1]));
    check("b.hold_count",  32'(b_hold), 32'(m_hold[1]));
  endtask

  // Inputs change at posedge+1; outputs are sampled at posedge+1 too.
  task automatic step(input logic en, input logic [3:0] din, input logic [3:0] proc);
    sample_en = en; dirinput = din; processed = proc;
    @(posedge clk);
    if (en) model_strobe(din, proc);
    else begin m_chg[0] = 1'b0; m_chg[1] = 1'b0; end
    #1 check_all();
  endtask

  task automatic async_reset();
    reset_n = 1'b0;
    #2;
    model_reset();
    check_all();
    check("rst.a_dir",  32'(a_dir),  32'h0);
    check("rst.a_hold", 32'(a_hold), 32'h0);
    #2 reset_n = 1'b1;
  endtask

  initial begin
    logic       seen_chg;
    logic [3:0] din;
    reset_n = 1'b0; sample_en = 1'b0; dirinput = '0; processed = '0;
    model_reset();
    #7 check_all();
    check("reset.a_oldp", 32'(a_oldp), 32'h0);
    #1 reset_n = 1'b1;

    // Press up and hold: stable after the 3rd strobe, then hold counts up
    step(1, 4'b1000, 4'h0);
    check("p1.b_dir_db1", 32'(b_dir), 32'h8);
    step(1, 4'b1000, 4'h0);
    check("p1.a_dir_early", 32'(a_dir), 32'h0);
    step(1, 4'b1000, 4'h0);
    check("p1.a_dir", 32'(a_dir), 32'h8);
    check("p1.a_chg", 32'(a_chg), 32'h1);
    for (int i = 1; i <= 3; i++) begin
      step(1, 4'b1000, 4'h0);
      check("p1.a_hold", 32'(a_hold), 32'(i));
      check("p1.a_chg_low", 32'(a_chg), 32'h0);
    end

    // Back to neutral, then a 2-strobe glitch on left
    for (int i = 0; i < 3; i++) step(1, 4'b0000, 4'h0);
    seen_chg = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1, (i < 2) ? 4'b0010 : 4'b0000, 4'h0);
      seen_chg |= a_chg;
    end
    check("glitch.a_dir", 32'(a_dir), 32'h0);
    check("glitch.a_chg", 32'(seen_chg), 32'h0);

    // Feedback capture and hold while sample_en is low
    step(1, 4'b0000, 4'b0001);
    check("fb.a_oldp", 32'(a_oldp), 32'h1);
    for (int i = 0; i < 10; i++) step(0, 4'($urandom), 4'($urandom));
    check("fb.a_oldp_hold", 32'(a_oldp), 32'h1);
    step(1, 4'b0000, 4'b0000);
    check("fb.a_oldp_neutral", 32'(a_oldp), 32'h0);

    // Narrow hold counter saturates, then clears on a change
    for (int i = 0; i < 6; i++) step(1, 4'b0000, 4'h0);
    check("sat.b_hold", 32'(b_hold), 32'h3);
    step(1, 4'b0001, 4'h0);
    check("sat.b_hold_clear", 32'(b_hold), 32'h0);

    // Reset while a bit is pending with two strobes counted
    step(1, 4'b0000, 4'h0);
    step(1, 4'b0000, 4'h0);
    step(1, 4'b0101, 4'h3);
    step(1, 4'b0101, 4'h3);
    #3 async_reset();
    step(1, 4'b0101, 4'h0);
    step(1, 4'b0101, 4'h0);
    check("rst.fresh_early", 32'(a_dir), 32'h0);
    step(1, 4'b0101, 4'h0);
    check("rst.fresh", 32'(a_dir), 32'h5);

    // Opposing directions on the vertical axis
    for (int i = 0; i < 3; i++) step(1, 4'b1000, 4'h0);
    check("socd.up", 32'(a_dir), 32'h8);
    for (int i = 0; i < 3; i++) step(1, 4'b1100, 4'h0);
`ifdef DIRECTION_HISTORY_SOCD_EN
    check("socd.down_wins", 32'(a_dir), 32'h4);
`else
    check("socd.both_raw", 32'(a_dir), 32'hC);
`endif
    for (int i = 0; i < 3; i++) step(1, 4'b1000, 4'h0);
    check("socd.release_down", 32'(a_dir), 32'h8);
    for (int i = 0; i < 3; i++) step(1, 4'b0000, 4'h0);
    for (int i = 0; i < 3; i++) step(1, 4'b1100, 4'h0);
`ifdef DIRECTION_HISTORY_SOCD_EN
    check("socd.same_strobe", 32'(a_dir), 32'h0);
`else
    check("socd.same_strobe", 32'(a_dir), 32'hC);
`endif

    // Randomised run: held inputs that change occasionally, gapped strobes
    din = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) din = 4'($urandom);
      step(($urandom_range(9) < 7), din, 4'($urandom));
      if (i == 200) #3 async_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
